// File: rtl/mac_core_pkg.sv
// ============================================================
// mac_core_pkg : shared widths, pipeline latency, saturation
// Revision     : 1.0
// ============================================================
`default_nettype none

package mac_core_pkg;

  localparam int PIPE_LAT  = 3;
  // Working width for clamping; must cover ACC_W + 2*DATA_W + 1.
  localparam int SAT_MAX_W = 256;

  function automatic int pair_aw(input int depth);
    return $clog2(depth / 2);
  endfunction

  function automatic int word_aw(input int depth);
    return $clog2(depth);
  endfunction

  function automatic logic signed [SAT_MAX_W-1:0] sat_clamp(
    input logic signed [SAT_MAX_W-1:0] v,
    input logic                        sgn,
    input int unsigned                 acc_w
  );
    logic signed [SAT_MAX_W-1:0] one;
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    one = {{(SAT_MAX_W-1){1'b0}}, 1'b1};
    if (sgn) begin
      hi = (one <<< (acc_w - 1)) - one;
      lo = -(one <<< (acc_w - 1));
    end else begin
      hi = (one <<< acc_w) - one;
      lo = '0;
    end
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_bank_ram.sv
// ============================================================
// mac_bank_ram : even/odd weight banks, pair write, one word read
// Revision     : 1.0
// ============================================================
`default_nettype none

module mac_bank_ram
  import mac_core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [pair_aw(DEPTH)-1:0]   wr_addr,
  input  logic [2*DATA_W-1:0]         wr_data,
  input  logic [word_aw(DEPTH)-1:0]   rd_addr,
  output logic [DATA_W-1:0]           rd_data
);

  localparam int c_PAW = pair_aw(DEPTH);

  logic [DATA_W-1:0] r_mem_even [DEPTH/2];
  logic [DATA_W-1:0] r_mem_odd  [DEPTH/2];
  logic [DATA_W-1:0] r_rd_even;
  logic [DATA_W-1:0] r_rd_odd;
  logic              r_sel;

  // Write-first is avoided: a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem_even[wr_addr] <= wr_data[DATA_W-1:0];
      r_mem_odd[wr_addr]  <= wr_data[2*DATA_W-1:DATA_W];
    end
    r_rd_even <= r_mem_even[rd_addr[c_PAW:1]];
    r_rd_odd  <= r_mem_odd[rd_addr[c_PAW:1]];
    r_sel     <= rd_addr[0];
  end

  assign rd_data = r_sel ? r_rd_odd : r_rd_even;

endmodule

`default_nettype wire

// File: rtl/mac_core_p.sv
// ============================================================
// mac_core_p : 3-stage weight x source MAC with chain drain
// Revision   : 1.0
// ============================================================
`default_nettype none

module mac_core_p
  import mac_core_pkg::*;
#(
  parameter int   DATA_W         = 32,
  parameter int   ACC_W          = 32,
  parameter int   DEPTH          = 128,
  parameter logic SAT_EN_DEFAULT = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mat_v,
  input  logic [pair_aw(DEPTH)-1:0]  mat_a,
  input  logic [2*DATA_W-1:0]        mat_d,
  input  logic                       init,
  input  logic                       exec,
  input  logic [word_aw(DEPTH)-1:0]  exec_mat_addr,
  input  logic [DATA_W-1:0]          exec_src_data,
  input  logic                       signed_mode,
  input  logic                       sat_en,
  input  logic                       update,
  input  logic                       out_period,
  input  logic [ACC_W-1:0]           acc_next,
  output logic [ACC_W-1:0]           acc,
  output logic                       ovf,
  output logic                       busy
);

  localparam int c_SUM_W = ACC_W + 2*DATA_W + 1;

  logic                  r_v1, r_v2, r_v3;
  logic                  r_i1, r_i2, r_i3;
  logic                  r_sgn1, r_sgn2, r_sat1, r_sat2;
  logic [DATA_W-1:0]     r_w2, r_s2;
  logic [ACC_W-1:0]      r_acc_left, r_acc_right;
  logic                  r_ovf;

  logic [DATA_W-1:0]     w_weight;
  logic [2*DATA_W-1:0]   w_prod;
  logic [c_SUM_W-1:0]    w_acc_ext, w_prod_ext, w_sum;
  logic [SAT_MAX_W-1:0]  w_sum_x, w_clamped;
  logic                  w_ovf;
  logic [ACC_W-1:0]      w_res;

  mac_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .wr_en   (mat_v),
    .wr_addr (mat_a),
    .wr_data (mat_d),
    .rd_addr (exec_mat_addr),
    .rd_data (w_weight)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;  r_v2   <= 1'b0;  r_v3 <= 1'b0;
      r_i1   <= 1'b0;  r_i2   <= 1'b0;  r_i3 <= 1'b0;
      r_sgn1 <= 1'b0;  r_sgn2 <= 1'b0;
      r_sat1 <= SAT_EN_DEFAULT;
      r_sat2 <= SAT_EN_DEFAULT;
      r_w2   <= '0;
      r_s2   <= '0;
    end else begin
      r_v1   <= exec;  r_v2 <= r_v1;  r_v3 <= r_v2;
      r_i1   <= init;  r_i2 <= r_i1;  r_i3 <= r_i2;
      if (exec) begin
        r_sgn1 <= signed_mode;
        r_sat1 <= sat_en;
      end
      // Source word arrives one cycle after exec, aligned with the RAM output.
      if (r_v1) begin
        r_sgn2 <= r_sgn1;
        r_sat2 <= r_sat1;
        r_w2   <= w_weight;
        r_s2   <= exec_src_data;
      end
    end
  end

  always_comb begin
    if (r_sgn2) begin
      w_prod     = $signed({{DATA_W{r_w2[DATA_W-1]}}, r_w2}) *
                   $signed({{DATA_W{r_s2[DATA_W-1]}}, r_s2});
      w_acc_ext  = {{(c_SUM_W-ACC_W){r_acc_left[ACC_W-1]}}, r_acc_left};
      w_prod_ext = {{(c_SUM_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    end else begin
      w_prod     = {{DATA_W{1'b0}}, r_w2} * {{DATA_W{1'b0}}, r_s2};
      w_acc_ext  = {{(c_SUM_W-ACC_W){1'b0}}, r_acc_left};
      w_prod_ext = {{(c_SUM_W-2*DATA_W){1'b0}}, w_prod};
    end
    w_sum     = w_acc_ext + w_prod_ext;
    w_sum_x   = {{(SAT_MAX_W-c_SUM_W){w_sum[c_SUM_W-1]}}, w_sum};
    w_clamped = sat_clamp(w_sum_x, r_sgn2, ACC_W);
    w_ovf     = (w_clamped != w_sum_x);
    w_res     = r_sat2 ? w_clamped[ACC_W-1:0] : w_sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_left  <= '0;
      r_acc_right <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (r_i2) begin
        r_acc_left <= '0;
        r_ovf      <= 1'b0;
      end else if (r_v2) begin
        r_acc_left <= w_res;
        r_ovf      <= r_ovf | w_ovf;
      end
      if (out_period) r_acc_right <= acc_next;
    end
  end

  assign acc  = update ? r_acc_left : r_acc_right;
  assign ovf  = r_ovf;
  assign busy = r_v1 | r_v2 | r_v3 | r_i1 | r_i2 | r_i3;

endmodule

`default_nettype wire

// File: tb/tb_mac_core_p.sv
// ============================================================
// tb_mac_core_p : directed vectors for mac_core_p
// Revision      : 1.0
// ============================================================
`default_nettype none

module tb_mac_core_p;

  localparam int DATA_W = 32;
  localparam int ACC_W  = 32;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mat_v;
  logic [5:0]        mat_a;
  logic [63:0]       mat_d;
  logic              init, exec;
  logic [6:0]        exec_mat_addr;
  logic [31:0]       exec_src_data;
  logic              signed_mode, sat_en, update, out_period;
  logic [31:0]       acc_next;
  logic [31:0]       acc;
  logic              ovf, busy;

  int n_tot = 0;
  int n_bad = 0;

  mac_core_p #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .SAT_EN_DEFAULT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .mat_v(mat_v), .mat_a(mat_a), .mat_d(mat_d),
    .init(init), .exec(exec), .exec_mat_addr(exec_mat_addr),
    .exec_src_data(exec_src_data), .signed_mode(signed_mode), .sat_en(sat_en),
    .update(update), .out_period(out_period), .acc_next(acc_next),
    .acc(acc), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic write_pair(input logic [5:0] a, input logic [63:0] d);
    mat_v = 1'b1; mat_a = a; mat_d = d;
    tick();
    mat_v = 1'b0;
  endtask

  task automatic do_init;
    init = 1'b1;
    tick();
    init = 1'b0;
    tick();
    tick();
  endtask

  task automatic run_mac(input logic [6:0] a, input logic [31:0] s,
                         input logic sg, input logic st);
    exec = 1'b1; exec_mat_addr = a; signed_mode = sg; sat_en = st;
    tick();
    exec = 1'b0; exec_src_data = s;
    tick();
    exec_src_data = '0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; mat_v = 0; mat_a = '0; mat_d = '0; init = 0; exec = 0;
    exec_mat_addr = '0; exec_src_data = '0; signed_mode = 0; sat_en = 0;
    update = 1'b1; out_period = 0; acc_next = '0;
    tick();
    tick();
    chk("reset_acc", acc, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Basic MAC: word1=7, src=3
    write_pair(6'd0, {32'd7, 32'd5});
    exec = 1'b1; exec_mat_addr = 7'd1;
    tick();
    chk("busy_c1", busy, 1);
    exec = 1'b0; exec_src_data = 32'd3;
    tick();
    chk("busy_c2", busy, 1);
    exec_src_data = '0;
    tick();
    chk("busy_c3", busy, 1);
    chk("mac_21", acc, 21);
    tick();
    chk("busy_idle", busy, 0);

    // Back-to-back 0,1,0 with src 2
    do_init();
    chk("init_clear", acc, 0);
    exec = 1'b1; exec_mat_addr = 7'd0;
    tick();
    exec_mat_addr = 7'd1; exec_src_data = 32'd2;
    tick();
    exec_mat_addr = 7'd0;
    tick();
    exec = 1'b0;
    tick();
    exec_src_data = '0;
    tick();
    chk("b2b_34", acc, 34);
    init = 1'b1;
    tick();
    init = 1'b0;
    chk("init_s1", acc, 34);
    tick();
    chk("init_s2", acc, 34);
    tick();
    chk("init_s3", acc, 0);

    // Signed negative product
    write_pair(6'd5, {32'd0, 32'hFFFF_FFFD});
    run_mac(7'd10, 32'd5, 1'b1, 1'b0);
    chk("signed_neg", acc, 32'hFFFF_FFF1);
    chk("signed_ovf", ovf, 0);

    // Signed saturation
    write_pair(6'd1, {32'd0, 32'h7FFF_FFFF});
    do_init();
    run_mac(7'd2, 32'd2, 1'b1, 1'b1);
    run_mac(7'd2, 32'd2, 1'b1, 1'b1);
    chk("sat_acc", acc, 32'h7FFF_FFFF);
    chk("sat_ovf", ovf, 1);
    do_init();
    chk("sat_init_acc", acc, 0);
    chk("sat_init_ovf", ovf, 0);

    // Unsigned wrap
    write_pair(6'd2, {32'd0, 32'hFFFF_FFFF});
    run_mac(7'd4, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("wrap_acc", acc, 32'h0000_0001);
    chk("wrap_ovf", ovf, 1);

    // init and exec entering together: init wins
    exec = 1'b1; init = 1'b1; exec_mat_addr = 7'd0;
    tick();
    exec = 1'b0; init = 1'b0; exec_src_data = 32'd9;
    tick();
    exec_src_data = '0;
    tick();
    chk("init_wins_acc", acc, 0);
    chk("init_wins_ovf", ovf, 0);

    // Chain
    write_pair(6'd4, {32'd0, 32'd9});
    run_mac(7'd8, 32'd1, 1'b0, 1'b0);
    chk("chain_left", acc, 9);
    update = 1'b0;
    #1;
    chk("chain_right0", acc, 0);
    update = 1'b1; out_period = 1'b1; acc_next = 32'd4;
    tick();
    chk("chain_upd_shift", acc, 9);
    update = 1'b0; out_period = 1'b0; acc_next = 32'd77;
    #1;
    chk("chain_shift", acc, 4);
    tick();
    chk("chain_hold", acc, 4);
    update = 1'b1;

    // Reset one cycle after exec
    exec = 1'b1; exec_mat_addr = 7'd0;
    tick();
    exec = 1'b0; exec_src_data = 32'd3;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    tick();
    rst_n = 1'b1; exec_src_data = '0;
    chk("rst_left", acc, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_nolate", acc, 0);
      chk("rst_busy_after", busy, 0);
    end
    update = 1'b0;
    #1;
    chk("rst_right", acc, 0);
    update = 1'b1;

    // Read-during-write returns old word
    write_pair(6'd3, {32'd11, 32'd13});
    do_init();
    mat_v = 1'b1; mat_a = 6'd3; mat_d = {32'd100, 32'd200};
    exec = 1'b1; exec_mat_addr = 7'd6;
    tick();
    mat_v = 1'b0; exec = 1'b0; exec_src_data = 32'd1;
    tick();
    exec_src_data = '0;
    tick();
    chk("rdw_old", acc, 13);
    run_mac(7'd6, 32'd1, 1'b0, 1'b0);
    chk("rdw_new_even", acc, 213);
    run_mac(7'd7, 32'd1, 1'b0, 1'b0);
    chk("rdw_new_odd", acc, 313);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mac_core_p.md
Name: mac_core_p

Overview:
Parametrised successor to the per-core matrix-vector MAC element of the accelerator array. Each instance stores DEPTH weight words, written two at a time from the host loader. It multiplies a stored weight by a streamed source word and accumulates the product. Adds reset, signed/unsigned mode, optional saturation with a sticky overflow flag, and a pipeline-busy indication. The accumulator still drains through the inter-core acc shift chain.

Parameters:
DATA_W, 32, width of weight and source operands
ACC_W, 32, accumulator width (ACC_W >= DATA_W)
DEPTH, 128, weight words per core (even, power of 2)
SAT_EN_DEFAULT, 0, saturation mode used when sat_en is tied to it

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mat_v  in  1  weight write strobe
mat_a  in  $clog2(DEPTH/2)  weight pair address
mat_d  in  2*DATA_W  weight pair: [DATA_W-1:0] goes to even word 2*mat_a; upper half goes to odd word 2*mat_a+1
init  in  1  clear accumulator (pipeline-aligned)
exec  in  1  issue one MAC
exec_mat_addr  in  $clog2(DEPTH)  weight word index; LSB selects bank
exec_src_data  in  DATA_W  source operand, presented the cycle AFTER exec
signed_mode  in  1  1 = two's-complement operands/accumulate; sampled with exec
sat_en  in  1  1 = saturate, 0 = wrap; sampled with exec
update  in  1  selects acc_left onto acc (parallel load of chain)
out_period  in  1  shift enable: acc_right <= acc_next
acc_next  in  ACC_W  acc of neighbouring core in chain
acc  out  ACC_W  update ? acc_left : acc_right (combinational mux)
ovf  out  1  sticky saturation/overflow flag
busy  out  1  any MAC or init in flight

Behaviour:
- Reset: acc_left=0, acc_right=0, ovf=0, all pipeline valid bits 0, so busy=0. Weight RAM is not reset; contents are undefined until written.
- Reset asserted mid-operation kills all in-flight MACs/inits. After release, no late accumulate occurs.
- Write: on mat_v, both banks are written at index mat_a in the same cycle.
- Read-during-write to the same word returns the OLD data.
- Pipeline (exec issued at edge t):
  - t+1: bank word registered. Bank chosen by exec_mat_addr[0], delayed alongside the read.
  - t+2: operands registered (weight, exec_src_data), plus mode bits.
  - t+3: acc_left updated.
  - Result is visible on acc (with update=1) after edge t+3.
- One MAC per cycle is sustained. Back-to-back exec is allowed with no bubbles.
- init travels through the same 3-stage valid pipe. At stage 3 it sets acc_left=0 and ovf=0.
- If init and exec reach stage 3 together, init wins and the product is discarded.
- Arithmetic:
  - The product is the full 2*DATA_W width, signed or unsigned per the sampled signed_mode.
  - Sum = acc_left + product, computed at ACC_W+2*DATA_W+1 bits.
  - Wrap (sat_en=0): truncate to ACC_W. ovf is set if the exact sum is outside the ACC_W range.
  - Saturate (sat_en=1): clamp to the signed range [-2^(ACC_W-1), 2^(ACC_W-1)-1] or the unsigned range [0, 2^ACC_W-1], and set ovf.
  - ovf stays set until init or reset.
- Chain: out_period loads acc_right from acc_next every cycle it is high.
- update is purely a combinational select. update and out_period together are legal: acc shows acc_left while acc_right still shifts.
- busy = OR of the three stage-valid bits (exec or init).
- exec with no weight written gives an undefined product but correct control behaviour.

Decomposition:
- Package mac_core_pkg:
  - width helper functions (addr widths from DEPTH)
  - sat_clamp function (value, signed, ACC_W)
  - localparam PIPE_LAT = 3
- Sub-module mac_bank_ram: dual-bank (even/odd) weight store with pair write and single registered word read selected by LSB. Inferred as block RAM.

Test Plan:
- Reset, then write pair mat_a=0, mat_d={32'd7,32'd5}. exec addr=1 with src=3 next cycle; update=1. -> acc=21 after 3 edges; busy high for 3 cycles.
- init, then back-to-back exec addr 0,1,0 with src 2,2,2. -> acc_left=5*2+7*2+5*2=34. The following init clears it to 0 at its stage 3.
- signed_mode=1, sat_en=1, ACC_W=32. Weight 32'h7FFFFFFF, src 2, repeated 2 times. -> acc=32'h7FFFFFFF, ovf=1. After init: acc=0, ovf=0.
- sat_en=0, unsigned, weight 32'hFFFFFFFF, src 32'hFFFFFFFF. -> acc=32'h00000001 (wrapped), ovf=1.
- Chain: acc_left=9 in core, update pulse, then out_period with acc_next=4. -> acc=9 during update; acc=4 the cycle after the shift.
- Assert rst_n low one cycle after exec. -> after release, acc_left=0, busy=0, and no later change to acc_left.
- Write mat_a=3 while exec reads word 6 in the same cycle. -> the MAC uses the pre-write value.
